// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding and pipeline hazard control
//
// Purpose:
//   Selects the freshest value for each EX-stage source operand, detects
//   load-use hazards against the ID stage, and freezes the pipe while the
//   data memory is busy. A one-entry WB-hold register keeps the last
//   retired write so an operand read one cycle after WB still sees it.
//
// Optional feature:
//   FWD_STALL_CNT_EN - when defined, a 32-bit wrapping counter of stalled
//   cycles drives stall_cnt_o; otherwise stall_cnt_o is tied to zero.
//
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   id_rs_i             ID-stage source addresses, port k at [k*REG_AW +: REG_AW]
//   ex_rs_i             EX-stage source addresses
//   ex_rf_data_i        register-file read data for the EX sources
//   id_ex_rd_i/we/load  destination, write enable, load flag of the EX instruction
//   ex_mem_rd_i/we/data destination, write enable, ALU result in MEM
//   mem_wb_rd_i/we/data destination, write enable, result in WB
//   mem_busy_i          data memory not ready
//   ex_rs_data_o        forwarded operands
//   fwd_sel_o           per-port source: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 WB-hold
//   stall_o             freeze PC, IF/ID and ID/EX
//   bubble_o            insert a NOP into ID/EX
//   stall_cnt_o         stalled-cycle count

module fwd_hazard_unit #(
    parameter int XLEN   = 32,
    parameter int NUM_RD = 2,
    parameter int REG_AW = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_RD*REG_AW-1:0] id_rs_i,
    input  logic [NUM_RD*REG_AW-1:0] ex_rs_i,
    input  logic [NUM_RD*XLEN-1:0]   ex_rf_data_i,
    input  logic [REG_AW-1:0]        id_ex_rd_i,
    input  logic                     id_ex_we_i,
    input  logic                     id_ex_load_i,
    input  logic [REG_AW-1:0]        ex_mem_rd_i,
    input  logic                     ex_mem_we_i,
    input  logic [XLEN-1:0]          ex_mem_data_i,
    input  logic [REG_AW-1:0]        mem_wb_rd_i,
    input  logic                     mem_wb_we_i,
    input  logic [XLEN-1:0]          mem_wb_data_i,
    input  logic                     mem_busy_i,
    output logic [NUM_RD*XLEN-1:0]   ex_rs_data_o,
    output logic [NUM_RD*2-1:0]      fwd_sel_o,
    output logic                     stall_o,
    output logic                     bubble_o,
    output logic [31:0]              stall_cnt_o
);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_MWB  = 2'b01;
    localparam logic [1:0] SEL_EXM  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              hold_vld_q;
    logic [REG_AW-1:0] hold_rd_q;
    logic [XLEN-1:0]   hold_data_q;

    logic              load_use;

    // ------------------------------------------------------------------
    // Memory-wait FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (mem_busy_i)  state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_busy_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // WB-hold register
    // While the memory is stalled the WB stage is frozen, so the hold entry
    // must not be overwritten or dropped; it still describes the last
    // write that retired before the stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hold_vld_q  <= 1'b0;
            hold_rd_q   <= '0;
            hold_data_q <= '0;
        end else if (state_q != MEM_WAIT) begin
            if (mem_wb_we_i && (mem_wb_rd_i != '0)) begin
                hold_vld_q  <= 1'b1;
                hold_rd_q   <= mem_wb_rd_i;
                hold_data_q <= mem_wb_data_i;
            end else begin
                hold_vld_q  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-port forwarding mux, priority EX/MEM > MEM/WB > WB-hold > regfile.
    // Address 0 is hard-wired zero and never forwarded. Selection stays live
    // during stalls so a frozen EX instruction keeps tracking its operands.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        logic [REG_AW-1:0] rs;
        logic [XLEN-1:0]   rf_data;
        logic              hit_exm;
        logic              hit_mwb;
        logic              hit_hold;
        logic [1:0]        sel;
        logic [XLEN-1:0]   data;

        assign rs      = ex_rs_i[k*REG_AW +: REG_AW];
        assign rf_data = ex_rf_data_i[k*XLEN +: XLEN];

        assign hit_exm  = (rs != '0) && ex_mem_we_i && (ex_mem_rd_i == rs);
        assign hit_mwb  = (rs != '0) && mem_wb_we_i && (mem_wb_rd_i == rs);
        assign hit_hold = (rs != '0) && hold_vld_q  && (hold_rd_q   == rs);

        always_comb begin
            sel  = SEL_RF;
            data = rf_data;
            if (!rst_n_i) begin
                sel  = SEL_RF;
                data = rf_data;
            end else if (hit_exm) begin
                sel  = SEL_EXM;
                data = ex_mem_data_i;
            end else if (hit_mwb) begin
                sel  = SEL_MWB;
                data = mem_wb_data_i;
            end else if (hit_hold) begin
                sel  = SEL_HOLD;
                data = hold_data_q;
            end
        end

        assign ex_rs_data_o[k*XLEN +: XLEN] = data;
        assign fwd_sel_o[k*2 +: 2]          = sel;
    end

    // ------------------------------------------------------------------
    // Load-use detection: a load in EX whose destination is read in ID
    // cannot be forwarded in time and needs one bubble.
    // ------------------------------------------------------------------
    always_comb begin
        load_use = 1'b0;
        if (id_ex_load_i && id_ex_we_i && (id_ex_rd_i != '0)) begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (id_rs_i[k*REG_AW +: REG_AW] == id_ex_rd_i) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    // A memory wait freezes every stage, so no bubble is inserted; a pending
    // load-use is naturally re-evaluated once mem_busy_i drops.
    assign stall_o  = rst_n_i && (mem_busy_i || load_use);
    assign bubble_o = rst_n_i && load_use && !mem_busy_i;

    // ------------------------------------------------------------------
    // Optional stall counter
    // ------------------------------------------------------------------
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit

module tb_fwd_hazard_unit;

`ifdef FWD_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [31:0] R0 = 32'h1000_0000;
    localparam logic [31:0] R1 = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  id_rs;
    logic [7:0]  ex_rs;
    logic [63:0] ex_rf;
    logic [3:0]  ide_rd;
    logic        ide_we;
    logic        ide_ld;
    logic [3:0]  exm_rd;
    logic        exm_we;
    logic [31:0] exm_d;
    logic [3:0]  mwb_rd;
    logic        mwb_we;
    logic [31:0] mwb_d;
    logic        busy;
    logic [63:0] data_o;
    logic [3:0]  sel_o;
    logic        stall;
    logic        bubble;
    logic [31:0] cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.XLEN(32), .NUM_RD(2), .REG_AW(4)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .id_rs_i       (id_rs),
        .ex_rs_i       (ex_rs),
        .ex_rf_data_i  (ex_rf),
        .id_ex_rd_i    (ide_rd),
        .id_ex_we_i    (ide_we),
        .id_ex_load_i  (ide_ld),
        .ex_mem_rd_i   (exm_rd),
        .ex_mem_we_i   (exm_we),
        .ex_mem_data_i (exm_d),
        .mem_wb_rd_i   (mwb_rd),
        .mem_wb_we_i   (mwb_we),
        .mem_wb_data_i (mwb_d),
        .mem_busy_i    (busy),
        .ex_rs_data_o  (data_o),
        .fwd_sel_o     (sel_o),
        .stall_o       (stall),
        .bubble_o      (bubble),
        .stall_cnt_o   (cnt)
    );

    typedef struct {
        logic [3:0]  rs0, rs1;
        logic [31:0] rf0, rf1;
        logic [3:0]  exm_rd;  logic exm_we; logic [31:0] exm_d;
        logic [3:0]  mwb_rd;  logic mwb_we; logic [31:0] mwb_d;
        logic [3:0]  ide_rd;  logic ide_we; logic ide_ld;
        logic [3:0]  id0, id1;
        logic        busy;
        logic [1:0]  esel0, esel1;
        logic [31:0] eout0, eout1;
        logic        estall, ebub;
    } vec_t;

    vec_t vt[11];

    // reference model state
    logic        m_wait;
    logic        m_hvld;
    logic [3:0]  m_hrd;
    logic [31:0] m_hdata;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        id_rs = '0; ex_rs = '0; ex_rf = {R1, R0};
        ide_rd = '0; ide_we = 1'b0; ide_ld = 1'b0;
        exm_rd = '0; exm_we = 1'b0; exm_d = '0;
        mwb_rd = '0; mwb_we = 1'b0; mwb_d = '0;
        busy = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        step();
        rst_n = 1'b1;
    endtask

    task automatic model_fwd(input logic [3:0] rs, input logic [31:0] rf,
                             output logic [1:0] sel, output logic [31:0] d);
        logic [3:0]  src_rd[3];
        logic        src_ok[3];
        logic [31:0] src_d[3];
        logic [1:0]  src_code[3];
        src_rd[0] = exm_rd; src_ok[0] = exm_we; src_d[0] = exm_d;   src_code[0] = 2'b10;
        src_rd[1] = mwb_rd; src_ok[1] = mwb_we; src_d[1] = mwb_d;   src_code[1] = 2'b01;
        src_rd[2] = m_hrd;  src_ok[2] = m_hvld; src_d[2] = m_hdata; src_code[2] = 2'b11;
        sel = 2'b00;
        d   = rf;
        if (rst_n && rs != 4'd0) begin
            for (int i = 0; i < 3; i++) begin
                if (src_ok[i] && src_rd[i] == rs) begin
                    sel = src_code[i];
                    d   = src_d[i];
                    break;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  es0, es1;
        logic [31:0] eo0, eo1;
        logic        lu, est, ebu;

        //          rs0 rs1 rf0 rf1 exm_rd we data          mwb_rd we data         ide rd we ld id0 id1 busy sel0  sel1  out0          out1          st bub
        vt[0]  = '{4'd3, 4'd4, R0, R1, 4'd3, 1, 32'hAAAA0000, 4'd3, 1, 32'h00005555, 4'd0, 0, 0, 4'd0, 4'd0, 0, 2'b10, 2'b00, 32'hAAAA0000, R1, 0, 0};
        vt[1]  = '{4'd0, 4'd0, R0, R1, 4'd0, 1, 32'hFFFFFFFF, 4'd0, 1, 32'hFFFFFFFF, 4'd0, 0, 0, 4'd0, 4'd0, 0, 2'b00, 2'b00, R0, R1, 0, 0};
        vt[2]  = '{4'd5, 4'd6, R0, R1, 4'd6, 0, 32'h11111111, 4'd5, 1, 32'h00005A5A, 4'd0, 0, 0, 4'd0, 4'd0, 0, 2'b01, 2'b00, 32'h00005A5A, R1, 0, 0};
        vt[3]  = '{4'd9, 4'd10, R0, R1, 4'd10, 1, 32'h0000CAFE, 4'd9, 1, 32'h0000BEEF, 4'd0, 0, 0, 4'd0, 4'd0, 0, 2'b01, 2'b10, 32'h0000BEEF, 32'h0000CAFE, 0, 0};
        vt[4]  = '{4'd0, 4'd0, R0, R1, 4'd0, 0, 32'h0, 4'd0, 0, 32'h0, 4'd7, 1, 1, 4'd1, 4'd7, 0, 2'b00, 2'b00, R0, R1, 1, 1};
        vt[5]  = '{4'd3, 4'd0, R0, R1, 4'd3, 1, 32'hAAAA0000, 4'd0, 0, 32'h0, 4'd7, 1, 1, 4'd7, 4'd2, 1, 2'b10, 2'b00, 32'hAAAA0000, R1, 1, 0};
        vt[6]  = '{4'd0, 4'd0, R0, R1, 4'd0, 0, 32'h0, 4'd0, 0, 32'h0, 4'd0, 0, 0, 4'd0, 4'd0, 1, 2'b00, 2'b00, R0, R1, 1, 0};
        vt[7]  = '{4'd0, 4'd0, R0, R1, 4'd0, 0, 32'h0, 4'd0, 0, 32'h0, 4'd0, 1, 1, 4'd0, 4'd0, 0, 2'b00, 2'b00, R0, R1, 0, 0};
        vt[8]  = '{4'd0, 4'd0, R0, R1, 4'd0, 0, 32'h0, 4'd0, 0, 32'h0, 4'd7, 0, 1, 4'd7, 4'd0, 0, 2'b00, 2'b00, R0, R1, 0, 0};
        vt[9]  = '{4'd0, 4'd0, R0, R1, 4'd0, 0, 32'h0, 4'd0, 0, 32'h0, 4'd7, 1, 0, 4'd7, 4'd7, 0, 2'b00, 2'b00, R0, R1, 0, 0};
        vt[10] = '{4'd15, 4'd15, R0, R1, 4'd15, 1, 32'hF0F0F0F0, 4'd15, 1, 32'h0F0F0F0F, 4'd15, 1, 1, 4'd15, 4'd0, 0, 2'b10, 2'b10, 32'hF0F0F0F0, 32'hF0F0F0F0, 1, 1};

        // reset behaviour: outputs gated, state cleared
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        busy = 1'b1; ide_rd = 4'd7; ide_we = 1'b1; ide_ld = 1'b1; id_rs = {4'd0, 4'd7};
        ex_rs = {4'd0, 4'd3}; exm_rd = 4'd3; exm_we = 1'b1; exm_d = 32'hAAAA0000;
        #1;
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst bubble", {31'd0, bubble}, 32'd0);
        chk("rst out0", data_o[31:0], R0);
        chk("rst sel0", {30'd0, sel_o[1:0]}, 32'd0);
        step();
        chk("rst cnt", cnt, 32'd0);
        set_idle();
        rst_n = 1'b1;
        step();

        // table-driven combinational vectors, each from a clean hold state
        for (int i = 0; i < 11; i++) begin
            ex_rs  = {vt[i].rs1, vt[i].rs0};
            ex_rf  = {vt[i].rf1, vt[i].rf0};
            exm_rd = vt[i].exm_rd; exm_we = vt[i].exm_we; exm_d = vt[i].exm_d;
            mwb_rd = vt[i].mwb_rd; mwb_we = vt[i].mwb_we; mwb_d = vt[i].mwb_d;
            ide_rd = vt[i].ide_rd; ide_we = vt[i].ide_we; ide_ld = vt[i].ide_ld;
            id_rs  = {vt[i].id1, vt[i].id0};
            busy   = vt[i].busy;
            #1;
            chk($sformatf("vec%0d sel0", i), {30'd0, sel_o[1:0]}, {30'd0, vt[i].esel0});
            chk($sformatf("vec%0d sel1", i), {30'd0, sel_o[3:2]}, {30'd0, vt[i].esel1});
            chk($sformatf("vec%0d out0", i), data_o[31:0], vt[i].eout0);
            chk($sformatf("vec%0d out1", i), data_o[63:32], vt[i].eout1);
            chk($sformatf("vec%0d stall", i), {31'd0, stall}, {31'd0, vt[i].estall});
            chk($sformatf("vec%0d bubble", i), {31'd0, bubble}, {31'd0, vt[i].ebub});
            set_idle();
            step();
        end

        // WB-hold: write retires at n, read at n+1
        do_reset();
        mwb_rd = 4'd5; mwb_we = 1'b1; mwb_d = 32'h00001234;
        step();
        mwb_we = 1'b0; ex_rs = {4'd5, 4'd0};
        #1;
        chk("hold sel1", {30'd0, sel_o[3:2]}, 32'd3);
        chk("hold out1", data_o[63:32], 32'h00001234);
        chk("hold sel0", {30'd0, sel_o[1:0]}, 32'd0);
        set_idle();

        // load-use: one stall+bubble cycle, then the bubble reaches EX
        do_reset();
        ide_rd = 4'd7; ide_we = 1'b1; ide_ld = 1'b1; id_rs = {4'd7, 4'd1};
        #1;
        chk("lu stall", {31'd0, stall}, 32'd1);
        chk("lu bubble", {31'd0, bubble}, 32'd1);
        step();
        ide_we = 1'b0; ide_ld = 1'b0; ide_rd = 4'd0;
        #1;
        chk("lu after stall", {31'd0, stall}, 32'd0);
        chk("lu after bubble", {31'd0, bubble}, 32'd0);
        chk("lu cnt", cnt, CNT_EN ? 32'd1 : 32'd0);
        set_idle();

        // memory wait of 4 cycles with hold valid for rd=2
        do_reset();
        mwb_rd = 4'd2; mwb_we = 1'b1; mwb_d = 32'hD00D0002;
        step();
        busy = 1'b1;
        #1;
        chk("mw stall c0", {31'd0, stall}, 32'd1);
        chk("mw bubble c0", {31'd0, bubble}, 32'd0);
        step();
        mwb_we = 1'b0; ex_rs = {4'd0, 4'd2};
        for (int j = 1; j < 4; j++) begin
            #1;
            chk($sformatf("mw stall c%0d", j), {31'd0, stall}, 32'd1);
            chk($sformatf("mw bubble c%0d", j), {31'd0, bubble}, 32'd0);
            chk($sformatf("mw sel0 c%0d", j), {30'd0, sel_o[1:0]}, 32'd3);
            chk($sformatf("mw out0 c%0d", j), data_o[31:0], 32'hD00D0002);
            step();
        end
        busy = 1'b0;
        #1;
        chk("mw end stall", {31'd0, stall}, 32'd0);
        chk("mw end sel0", {30'd0, sel_o[1:0]}, 32'd3);
        chk("mw cnt", cnt, CNT_EN ? 32'd4 : 32'd0);
        step();
        chk("mw exit hold kept", data_o[31:0], 32'hD00D0002);
        step();
        chk("mw hold dropped", {30'd0, sel_o[1:0]}, 32'd0);
        set_idle();

        // reset in the middle of a memory wait
        do_reset();
        mwb_rd = 4'd2; mwb_we = 1'b1; mwb_d = 32'h00002626;
        step();
        busy = 1'b1;
        step();
        mwb_we = 1'b0; ex_rs = {4'd0, 4'd2};
        rst_n = 1'b0;
        ide_rd = 4'd7; ide_we = 1'b1; ide_ld = 1'b1; id_rs = {4'd0, 4'd7};
        #1;
        chk("mwrst stall", {31'd0, stall}, 32'd0);
        chk("mwrst bubble", {31'd0, bubble}, 32'd0);
        chk("mwrst out0", data_o[31:0], R0);
        step();
        rst_n = 1'b1; busy = 1'b0; ide_we = 1'b0; ide_ld = 1'b0; ide_rd = 4'd0; id_rs = '0;
        #1;
        chk("mwrst after stall", {31'd0, stall}, 32'd0);
        chk("mwrst hold cleared", {30'd0, sel_o[1:0]}, 32'd0);
        chk("mwrst cnt", cnt, 32'd0);
        mwb_rd = 4'd4; mwb_we = 1'b1; mwb_d = 32'h00004444;
        step();
        mwb_we = 1'b0; ex_rs = {4'd4, 4'd0};
        #1;
        chk("mwrst idle reload sel1", {30'd0, sel_o[3:2]}, 32'd3);
        chk("mwrst idle reload out1", data_o[63:32], 32'h00004444);
        set_idle();

        // randomized run against the reference model
        do_reset();
        m_wait = 1'b0; m_hvld = 1'b0; m_hrd = '0; m_hdata = '0; m_cnt = '0;
        for (int c = 0; c < 600; c++) begin
            rst_n  = ($urandom_range(0, 24) != 0);
            ex_rs  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            id_rs  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            ex_rf  = {$urandom(), $urandom()};
            ide_rd = 4'($urandom_range(0, 3)); ide_we = 1'($urandom); ide_ld = 1'($urandom);
            exm_rd = 4'($urandom_range(0, 3)); exm_we = 1'($urandom); exm_d = $urandom();
            mwb_rd = 4'($urandom_range(0, 3)); mwb_we = 1'($urandom); mwb_d = $urandom();
            busy   = ($urandom_range(0, 9) < 3);
            #1;
            model_fwd(ex_rs[3:0], ex_rf[31:0], es0, eo0);
            model_fwd(ex_rs[7:4], ex_rf[63:32], es1, eo1);
            lu  = ide_ld && ide_we && (ide_rd != 0) && (ide_rd == id_rs[3:0] || ide_rd == id_rs[7:4]);
            est = rst_n && (busy || lu);
            ebu = rst_n && lu && !busy;
            chk($sformatf("rnd%0d sel0", c), {30'd0, sel_o[1:0]}, {30'd0, es0});
            chk($sformatf("rnd%0d sel1", c), {30'd0, sel_o[3:2]}, {30'd0, es1});
            chk($sformatf("rnd%0d out0", c), data_o[31:0], eo0);
            chk($sformatf("rnd%0d out1", c), data_o[63:32], eo1);
            chk($sformatf("rnd%0d stall", c), {31'd0, stall}, {31'd0, est});
            chk($sformatf("rnd%0d bubble", c), {31'd0, bubble}, {31'd0, ebu});
            chk($sformatf("rnd%0d cnt", c), cnt, m_cnt);
            @(posedge clk);
            if (!rst_n) begin
                m_wait = 1'b0; m_hvld = 1'b0; m_hrd = '0; m_hdata = '0; m_cnt = '0;
            end else begin
                if (!m_wait) begin
                    if (mwb_we && mwb_rd != 0) begin
                        m_hvld = 1'b1; m_hrd = mwb_rd; m_hdata = mwb_d;
                    end else begin
                        m_hvld = 1'b0;
                    end
                end
                if (CNT_EN && est) m_cnt = m_cnt + 32'd1;
                m_wait = busy;
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter NUM_RD, default 2, number of EX source-operand ports.
REQ-003 SHALL have parameter REG_AW, default 4, register-address width (RV32E: 16 registers).
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk_i  in  1  sole clock; all state on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- id_rs_i  in  NUM_RD*REG_AW  ID-stage source addresses; port k at bits [k*REG_AW +: REG_AW].
- ex_rs_i  in  NUM_RD*REG_AW  EX-stage source addresses.
- ex_rf_data_i  in  NUM_RD*XLEN  register-file read data for EX sources.
- id_ex_rd_i, id_ex_we_i, id_ex_load_i  in  REG_AW/1/1  destination, write enable and load flag of the instruction in EX.
- ex_mem_rd_i, ex_mem_we_i  in  REG_AW/1  destination and write enable of the instruction in MEM.
- ex_mem_data_i  in  XLEN  ALU result in MEM.
- mem_wb_rd_i, mem_wb_we_i  in  REG_AW/1  destination and write enable of the instruction in WB.
- mem_wb_data_i  in  XLEN  WB result.
- mem_busy_i  in  1  data memory not ready.
- ex_rs_data_o  out  NUM_RD*XLEN  forwarded operands.
- fwd_sel_o  out  NUM_RD*2  per-port source: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 WB-hold.
- stall_o  out  1  freeze PC, IF/ID and ID/EX.
- bubble_o  out  1  insert NOP into ID/EX.
- stall_cnt_o  out  32  stall-cycle count.

Function
REQ-005 SHALL select, per port k independently, using priority EX/MEM > MEM/WB > WB-hold > regfile; a source matches when its address equals rd and the corresponding we is 1.
REQ-006 SHALL never forward for address 0; port k with ex_rs = 0 SHALL select 00.
REQ-007 SHALL drive ex_rs_data_o and fwd_sel_o combinationally, zero-cycle latency.
REQ-008 SHALL contain a WB-hold register {hold_vld, hold_rd, hold_data} loaded with mem_wb_rd_i/mem_wb_data_i on each edge where mem_wb_we_i=1, mem_wb_rd_i != 0 and the FSM is not in MEM_WAIT; otherwise hold_vld SHALL clear when not in MEM_WAIT.
REQ-009 SHALL preserve hold contents unchanged throughout MEM_WAIT.
REQ-010 SHALL assert load-use hazard when id_ex_load_i=1, id_ex_we_i=1, id_ex_rd_i != 0 and id_ex_rd_i equals any id_rs port.
REQ-011 SHALL implement FSM states IDLE and MEM_WAIT; IDLE->MEM_WAIT on mem_busy_i=1; MEM_WAIT->IDLE on mem_busy_i=0.
REQ-012 SHALL set stall_o = mem_busy_i OR load-use hazard, combinationally.
REQ-013 SHALL set bubble_o = load-use hazard AND NOT mem_busy_i; memory wait freezes the whole pipe without a bubble.
REQ-014 SHALL, for simultaneous load-use and mem_busy_i, assert stall_o=1 and bubble_o=0, re-evaluating load-use after MEM_WAIT exits.
REQ-015 SHALL keep forwarding selection active during stalls.

Reset
REQ-016 SHALL, on a clock edge with rst_n_i=0, set state=IDLE, hold_vld=0, hold_rd=0, hold_data=0 and stall counter=0.
REQ-017 SHALL force stall_o=0 and bubble_o=0 while rst_n_i=0; ex_rs_data_o SHALL equal ex_rf_data_i while rst_n_i=0.
REQ-018 SHALL abandon MEM_WAIT on reset mid-operation, with no residual stall after rst_n_i returns to 1.

Configuration
REQ-019 SHALL, when macro FWD_STALL_CNT_EN is defined, increment a 32-bit counter each cycle stall_o=1, wrapping 0xFFFFFFFF->0, driven on stall_cnt_o.
REQ-020 SHALL, when FWD_STALL_CNT_EN is undefined, instantiate no counter and tie stall_cnt_o to 0.

Verification
REQ-021 SHALL cover: ex_rs[0]=3, ex_mem rd=3 we=1 data=0xAAAA0000, mem_wb rd=3 we=1 data=0x5555 -> sel[0]=10, out=0xAAAA0000.
REQ-022 SHALL cover: mem_wb rd=5 data=0x1234 written at cycle n, at n+1 ex_rs[1]=5 with no other match -> sel[1]=11, out=0x1234.
REQ-023 SHALL cover: ex_rs[0]=0, ex_mem rd=0 we=1 data=0xFFFFFFFF -> sel[0]=00, out=regfile data.
REQ-024 SHALL cover: id_ex load rd=7, id_rs[1]=7 -> stall_o=1, bubble_o=1 for exactly one cycle.
REQ-025 SHALL cover: mem_busy_i high 4 cycles with hold valid rd=2 -> stall_o=1 for 4 cycles, bubble_o=0, hold unchanged, stall_cnt_o +4 with macro defined and 0 without.
REQ-026 SHALL cover: rst_n_i low during MEM_WAIT -> next cycle state IDLE, hold_vld=0, stall_o=0 once mem_busy_i=0.
